// File: rtl/mips_pipeline_pkg.sv
// Shared pipeline constants: multiply/divide function codes and the
// multiply/divide unit state encoding.
package mips_pipeline_pkg;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Iterative ops step while the count is below this, then move to FINISH.
  localparam logic [5:0] MD_ITERS = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULTIPLY = 2'd1,
    ST_DIVIDE   = 2'd2,
    ST_FINISH   = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/multiply_divide_sign_correction.sv
// Sign handling around the unsigned multiply/divide datapath.
// Pre side turns raw operands into magnitudes plus sign flags; post side
// restores signs on the registered magnitude result (product, or
// quotient/remainder) and forces the divide-by-zero quotient.
module multiply_divide_sign_correction (
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] mag_a_o,
  output logic [31:0] mag_b_o,
  output logic        neg_a_o,
  output logic        neg_b_o,
  input  logic        is_div_i,
  input  logic        div0_i,
  input  logic        neg_a_i,
  input  logic        neg_b_i,
  input  logic [31:0] res_hi_i,
  input  logic [31:0] res_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_mag, prod_fix;

  assign neg_a_o = signed_i & a_i[31];
  assign neg_b_o = signed_i & b_i[31];
  assign mag_a_o = neg_a_o ? (~a_i + 32'd1) : a_i;
  assign mag_b_o = neg_b_o ? (~b_i + 32'd1) : b_i;

  assign prod_mag = {res_hi_i, res_lo_i};
  assign prod_fix = (neg_a_i ^ neg_b_i) ? (~prod_mag + 64'd1) : prod_mag;

  // Division: quotient negated on differing signs, remainder follows dividend.
  always_comb begin
    if (is_div_i) begin
      hi_o = neg_a_i ? (~res_hi_i + 32'd1) : res_hi_i;
      if (div0_i)                lo_o = 32'hFFFF_FFFF;
      else if (neg_a_i ^ neg_b_i) lo_o = ~res_lo_i + 32'd1;
      else                       lo_o = res_lo_i;
    end else begin
      hi_o = prod_fix[63:32];
      lo_o = prod_fix[31:0];
    end
  end

endmodule

// File: rtl/multiply_divide_unit.sv
// HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step restoring
// divide, MTHI/MTLO writes. Optional macro FAST_MULTIPLY_EN makes MULT/MULTU
// single-cycle (result registered, written one edge after acceptance,
// busy never raised).
module multiply_divide_unit
  import mips_pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [5:0]  ALU_function_execute,
  input  logic [31:0] source_A_execute,
  input  logic [31:0] source_B_execute,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);

  mdu_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic        is_div_q, is_div_d, div0_q, div0_d;
  logic        done_q, done_d, fast_q, fast_d;

  logic        op_signed;
  logic [31:0] mag_a, mag_b, corr_hi, corr_lo;
  logic        neg_a, neg_b;

  assign op_signed = (ALU_function_execute == FN_MULT) || (ALU_function_execute == FN_DIV);

  multiply_divide_sign_correction u_sign (
    .signed_i (op_signed),
    .a_i      (source_A_execute),
    .b_i      (source_B_execute),
    .mag_a_o  (mag_a),
    .mag_b_o  (mag_b),
    .neg_a_o  (neg_a),
    .neg_b_o  (neg_b),
    .is_div_i (is_div_q),
    .div0_i   (div0_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .res_hi_i (acc_hi_q),
    .res_lo_i (acc_lo_q),
    .hi_o     (corr_hi),
    .lo_o     (corr_lo)
  );

  // One iteration of each datapath: multiplier shifts out of acc_lo, product
  // shifts in; dividend shifts out of acc_lo, quotient bits shift in.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ge;
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_shift = {acc_hi_q, acc_lo_q[31]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift - {1'b0, opb_q};

  // Next-state: flush dominates, then per-state behaviour.
  always_comb begin
    state_d  = state_q;  cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q; acc_lo_d = acc_lo_q; opb_d = opb_q;
    hi_d     = hi_q;     lo_d     = lo_q;
    neg_a_d  = neg_a_q;  neg_b_d  = neg_b_q;
    is_div_d = is_div_q; div0_d   = div0_q;
    done_d   = 1'b0;     fast_d   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fast_q) begin
            hi_d   = corr_hi;
            lo_d   = corr_lo;
            done_d = 1'b1;
          end
          if (start) begin
            case (ALU_function_execute)
              FN_MTHI: hi_d = source_A_execute;
              FN_MTLO: lo_d = source_A_execute;
              FN_DIV, FN_DIVU: begin
                acc_hi_d = 32'd0;  acc_lo_d = mag_a;  opb_d = mag_b;
                neg_a_d  = neg_a;  neg_b_d  = neg_b;
                is_div_d = 1'b1;   div0_d   = (source_B_execute == 32'd0);
                cnt_d    = 6'd0;   state_d  = ST_DIVIDE;
              end
              FN_MULT, FN_MULTU: begin
                neg_a_d  = neg_a;  neg_b_d  = neg_b;
                is_div_d = 1'b0;   div0_d   = 1'b0;
`ifdef FAST_MULTIPLY_EN
                {acc_hi_d, acc_lo_d} = 64'(mag_a) * 64'(mag_b);
                fast_d = 1'b1;
`else
                acc_hi_d = 32'd0;  acc_lo_d = mag_a;  opb_d = mag_b;
                cnt_d    = 6'd0;   state_d  = ST_MULTIPLY;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_MULTIPLY: begin
          if (cnt_q == MD_ITERS) state_d = ST_FINISH;
          else begin
            acc_hi_d = mul_sum[32:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
            cnt_d    = cnt_q + 6'd1;
          end
        end
        ST_DIVIDE: begin
          if (cnt_q == MD_ITERS) state_d = ST_FINISH;
          else begin
            acc_hi_d = div_ge ? div_diff[31:0] : div_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], div_ge};
            cnt_d    = cnt_q + 6'd1;
          end
        end
        default: begin
          hi_d    = corr_hi;
          lo_d    = corr_lo;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE; cnt_q    <= 6'd0;
      acc_hi_q <= 32'd0;   acc_lo_q <= 32'd0; opb_q <= 32'd0;
      hi_q     <= 32'd0;   lo_q     <= 32'd0;
      neg_a_q  <= 1'b0;    neg_b_q  <= 1'b0;
      is_div_q <= 1'b0;    div0_q   <= 1'b0;
      done_q   <= 1'b0;    fast_q   <= 1'b0;
    end else begin
      state_q  <= state_d;  cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d; acc_lo_q <= acc_lo_d; opb_q <= opb_d;
      hi_q     <= hi_d;     lo_q     <= lo_d;
      neg_a_q  <= neg_a_d;  neg_b_q  <= neg_b_d;
      is_div_q <= is_div_d; div0_q   <= div0_d;
      done_q   <= done_d;   fast_q   <= fast_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule

// File: doc/multiply_divide_unit.md
MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 64-bit HI:LO.
REQ-002 The ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  abort any in-progress operation (execute-stage clear)
- start  input  1  operation request from execute stage, sampled when idle
- ALU_function_execute  input  6  function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
- source_A_execute  input  32  rs operand (forwarded)
- source_B_execute  input  32  rt operand (forwarded)
- hi_out  output  32  HI register
- lo_out  output  32  LO register
- busy  output  1  stall request to hazard unit
- done  output  1  one-cycle pulse when HI/LO take a new mult/div result
REQ-003 Reset SHALL be synchronous and active-high on port reset, with single clock clk.

Function
REQ-004 States SHALL be IDLE, MULTIPLY, DIVIDE, FINISH; busy SHALL equal (state != IDLE).
REQ-005 In IDLE, start=1 with any code outside the six listed SHALL be ignored.
REQ-006 In IDLE, start=1 with MTHI/MTLO SHALL write source_A_execute to HI/LO at the next edge; no busy, no done.
REQ-007 In IDLE, start=1 with DIV/DIVU SHALL capture operand magnitudes and sign flags at edge N, then enter DIVIDE with iteration count 0.
REQ-008 DIVIDE SHALL perform one restoring-division step per cycle for 32 cycles, then enter FINISH; FINISH SHALL apply sign correction, write HI/LO, pulse done, and return to IDLE.
REQ-009 HI/LO SHALL hold the new result from edge N+34; busy SHALL be high for cycles N+1 through N+34.
REQ-010 Signed division: quotient negated when operand signs differ; remainder takes dividend sign. 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-011 Divide by zero, signed or unsigned, SHALL give LO=0xFFFFFFFF, HI=source_A_execute, with normal latency.
REQ-012 MULT SHALL produce the signed 64-bit product and MULTU the unsigned one; HI=product[63:32], LO=product[31:0].
REQ-013 start while busy SHALL be ignored; the hazard unit guarantees it does not occur.
REQ-014 flush=1 SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and suppress done. Flush wins over start in the same cycle.
REQ-015 Operand inputs SHALL be sampled only at acceptance; later input changes SHALL not affect the result.

Reset
REQ-016 reset=1 SHALL set HI=0, LO=0, state=IDLE, busy=0, done=0, and iteration count=0. Reset overrides flush and start.
REQ-017 Reset asserted mid-operation SHALL discard the operation; done SHALL not pulse.

Configuration
REQ-018 Macro FAST_MULTIPLY_EN:
- Defined: MULT/MULTU SHALL complete single-cycle, writing HI/LO and pulsing done at edge N+1, with busy never asserted; MULTIPLY state unused.
- Undefined: MULT/MULTU SHALL use 32 shift-add iterations in MULTIPLY, then FINISH, with the same latency and busy profile as REQ-009.
REQ-019 Division behaviour SHALL be identical with or without the macro.

Structure
REQ-020 Function-code constants and the state enum SHALL live in shared package mips_pipeline_pkg.
REQ-021 Sign pre/post-correction SHALL be the combinational sub-module multiply_divide_sign_correction, shared by MULT and DIV paths.

Verification
REQ-022 DIVU: A=100, B=7 -> busy cycles N+1..N+34; at N+34 LO=14, HI=2; done pulses once.
REQ-023 DIV: A=0xFFFFFF9C (-100), B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
REQ-024 MULT: A=0xFFFFFFFF, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=1, LO=0xFFFFFFFE. Check both macro builds for latency.
REQ-025 DIVU with B=0, A=0x1234 -> LO=0xFFFFFFFF, HI=0x1234 at N+34.
REQ-026 DIV started, flush at cycle N+10 -> IDLE at N+11, HI/LO keep prior values, no done. Repeat with reset instead -> HI=LO=0.
REQ-027 MTHI A=0xDEADBEEF, then MTLO A=0x1 -> HI=0xDEADBEEF, LO=1; busy stays 0 throughout.
